// File: rtl/ignition_coil_channel.sv
// One ignition coil channel: charges at a programmable crank angle, fires at a second
// angle or when the dwell limit expires, and reports dwell and fault status.
module ignition_coil_channel #(
    parameter int unsigned ANGLE_W = 16,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hwag_start,
    input  logic [ANGLE_W-1:0] angle,
    input  logic               angle_tick,
    input  logic               cfg_we,
    input  logic               cfg_enable,
    input  logic [ANGLE_W-1:0] cfg_charge_angle,
    input  logic [ANGLE_W-1:0] cfg_fire_angle,
    input  logic [DWELL_W-1:0] cfg_max_dwell,
    output logic               coil,
    output logic               fire_pulse,
    output logic               dwell_timeout,
    output logic               sync_lost,
    output logic [DWELL_W-1:0] dwell_last
);

    localparam int unsigned TICKS_PER_REV = 3840;
    localparam logic [ANGLE_W-1:0] ANGLE_LIMIT = ANGLE_W'(TICKS_PER_REV);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_CHARGE = 2'd2,
        S_FIRE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               sh_en_q;
    logic [ANGLE_W-1:0] sh_chg_q, sh_fire_q;
    logic [DWELL_W-1:0] sh_max_q;
    logic               act_en_q;
    logic [ANGLE_W-1:0] act_chg_q, act_fire_q;
    logic [DWELL_W-1:0] act_max_q;
    logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic               coil_q, coil_d;
    logic               fire_q, fire_d;
    logic               timeout_q, timeout_d;
    logic               sync_lost_q, sync_lost_d;
    logic [DWELL_W-1:0] last_q, last_d;
    logic               load_act;
    logic               chg_hit, fire_hit, timeout_hit;
    logic               act_valid, sh_valid;

    // Targets outside one revolution can never match a real angle.
    assign chg_hit     = angle_tick && (angle == act_chg_q) && (act_chg_q < ANGLE_LIMIT);
    assign fire_hit    = angle_tick && (angle == act_fire_q) && (act_fire_q < ANGLE_LIMIT);
    assign act_valid   = act_chg_q != act_fire_q;
    assign sh_valid    = sh_chg_q != sh_fire_q;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + DWELL_W'(1);
    assign timeout_hit = (act_max_q != '0) && (cnt_inc == act_max_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coil_d      = 1'b0;
        fire_d      = 1'b0;
        timeout_d   = timeout_q;
        sync_lost_d = sync_lost_q;
        last_d      = last_q;
        load_act    = 1'b0;
        if (cfg_we) begin
            timeout_d   = 1'b0;
            sync_lost_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                load_act = 1'b1;
                if (hwag_start && act_en_q && act_valid) state_d = S_ARMED;
            end
            S_ARMED: begin
                // Active config is frozen here, so a host disable is seen through the shadow.
                if (!hwag_start || !sh_en_q) begin
                    state_d = S_IDLE;
                end else if (chg_hit) begin
                    state_d = S_CHARGE;
                    coil_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_CHARGE: begin
                coil_d = 1'b1;
                cnt_d  = cnt_inc;
                if (!hwag_start) begin
                    state_d     = S_IDLE;
                    coil_d      = 1'b0;
                    sync_lost_d = 1'b1;
                end else if (fire_hit || timeout_hit) begin
                    state_d = S_FIRE;
                    coil_d  = 1'b0;
                    fire_d  = 1'b1;
                    last_d  = cnt_inc;
                    if (!fire_hit) timeout_d = 1'b1;
                end
            end
            S_FIRE: begin
                load_act = 1'b1;
                state_d  = (hwag_start && sh_en_q && sh_valid) ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            coil_q      <= 1'b0;
            fire_q      <= 1'b0;
            timeout_q   <= 1'b0;
            sync_lost_q <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coil_q      <= coil_d;
            fire_q      <= fire_d;
            timeout_q   <= timeout_d;
            sync_lost_q <= sync_lost_d;
            last_q      <= last_d;
        end
    end

    // Shadow config from the host and active config used by the match logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en_q    <= 1'b0;
            sh_chg_q   <= '0;
            sh_fire_q  <= '0;
            sh_max_q   <= '0;
            act_en_q   <= 1'b0;
            act_chg_q  <= '0;
            act_fire_q <= '0;
            act_max_q  <= '0;
        end else begin
            if (cfg_we) begin
                sh_en_q   <= cfg_enable;
                sh_chg_q  <= cfg_charge_angle;
                sh_fire_q <= cfg_fire_angle;
                sh_max_q  <= cfg_max_dwell;
            end
            if (load_act) begin
                act_en_q   <= sh_en_q;
                act_chg_q  <= sh_chg_q;
                act_fire_q <= sh_fire_q;
                act_max_q  <= sh_max_q;
            end
        end
    end

    assign coil          = coil_q;
    assign fire_pulse    = fire_q;
    assign dwell_timeout = timeout_q;
    assign sync_lost     = sync_lost_q;
    assign dwell_last    = last_q;

endmodule

// File: tb/tb_ignition_coil_channel.sv
// Bench for ignition_coil_channel: directed scenarios with literal expectations, then
// random angle/config/sync traffic compared every cycle against a behavioural model.
module tb_ignition_coil_channel;

    localparam int unsigned ANGLE_W = 16;
    localparam int unsigned DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               hwag_start = 1'b0;
    logic [ANGLE_W-1:0] angle = '0;
    logic               angle_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic               cfg_enable = 1'b0;
    logic [ANGLE_W-1:0] cfg_charge_angle = '0;
    logic [ANGLE_W-1:0] cfg_fire_angle = '0;
    logic [DWELL_W-1:0] cfg_max_dwell = '0;
    logic               coil, fire_pulse, dwell_timeout, sync_lost;
    logic [DWELL_W-1:0] dwell_last;

    int n_chk = 0;
    int n_err = 0;

    ignition_coil_channel #(.ANGLE_W(ANGLE_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .hwag_start(hwag_start), .angle(angle),
        .angle_tick(angle_tick), .cfg_we(cfg_we), .cfg_enable(cfg_enable),
        .cfg_charge_angle(cfg_charge_angle), .cfg_fire_angle(cfg_fire_angle),
        .cfg_max_dwell(cfg_max_dwell), .coil(coil), .fire_pulse(fire_pulse),
        .dwell_timeout(dwell_timeout), .sync_lost(sync_lost), .dwell_last(dwell_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for charge angle, 2 coil on, 3 fire cycle.
    int m_ph = 0, m_dwell = 0;
    int sh_en = 0, sh_chg = 0, sh_fire = 0, sh_max = 0;
    int ac_en = 0, ac_chg = 0, ac_fire = 0, ac_max = 0;
    int e_coil = 0, e_fire = 0, e_to = 0, e_sl = 0, e_last = 0;

    task automatic model_step();
        int  nph;
        bit  hit_c, hit_f, forced, lost;
        if (rst) begin
            m_ph = 0; m_dwell = 0;
            sh_en = 0; sh_chg = 0; sh_fire = 0; sh_max = 0;
            ac_en = 0; ac_chg = 0; ac_fire = 0; ac_max = 0;
            e_coil = 0; e_fire = 0; e_to = 0; e_sl = 0; e_last = 0;
            return;
        end
        hit_c  = angle_tick && (int'(angle) == ac_chg) && (ac_chg < 3840);
        hit_f  = angle_tick && (int'(angle) == ac_fire) && (ac_fire < 3840);
        forced = 1'b0;
        lost   = 1'b0;
        nph    = m_ph;
        e_fire = 0;
        case (m_ph)
            0: if (hwag_start && ac_en != 0 && ac_chg != ac_fire) nph = 1;
            1: begin
                if (!hwag_start || sh_en == 0) nph = 0;
                else if (hit_c) begin nph = 2; m_dwell = 0; e_coil = 1; end
            end
            2: begin
                m_dwell++;
                if (!hwag_start) begin
                    nph = 0; e_coil = 0; lost = 1'b1;
                end else if (hit_f || (ac_max != 0 && m_dwell == ac_max)) begin
                    nph = 3; e_coil = 0; e_fire = 1; e_last = m_dwell;
                    forced = !hit_f;
                end
            end
            default: nph = (hwag_start && sh_en != 0 && sh_chg != sh_fire) ? 1 : 0;
        endcase
        if (m_ph == 0 || m_ph == 3) begin
            ac_en = sh_en; ac_chg = sh_chg; ac_fire = sh_fire; ac_max = sh_max;
        end
        if (cfg_we) begin
            sh_en = int'(cfg_enable); sh_chg = int'(cfg_charge_angle);
            sh_fire = int'(cfg_fire_angle); sh_max = int'(cfg_max_dwell);
            e_to = 0; e_sl = 0;
        end
        if (forced) e_to = 1;
        if (lost)   e_sl = 1;
        m_ph = nph;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_coil", longint'(coil), longint'(e_coil));
            chk("m_fire_pulse", longint'(fire_pulse), longint'(e_fire));
            chk("m_dwell_timeout", longint'(dwell_timeout), longint'(e_to));
            chk("m_sync_lost", longint'(sync_lost), longint'(e_sl));
            chk("m_dwell_last", longint'(dwell_last), longint'(e_last));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic step(input int a);
        angle = ANGLE_W'(a);
        angle_tick = 1'b1;
        @(posedge clk); #1;
        angle_tick = 1'b0;
    endtask

    task automatic cfg_write(input bit en, input int chg, input int fire, input int mx);
        cfg_enable = en;
        cfg_charge_angle = ANGLE_W'(chg);
        cfg_fire_angle = ANGLE_W'(fire);
        cfg_max_dwell = DWELL_W'(mx);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic reconfig(input bit en, input int chg, input int fire, input int mx);
        hwag_start = 1'b0;
        cfg_write(en, chg, fire, mx);
        idle(2);
        hwag_start = 1'b1;
        idle(2);
    endtask

    int r_chg = 0, r_fire = 0, cur = 0;

    task automatic rand_cfg();
        int r, chg, fire, mx;
        chg  = ($urandom_range(0, 19) == 0) ? 3840 + int'($urandom_range(0, 9))
                                            : int'($urandom_range(0, 3839));
        r    = int'($urandom_range(0, 9));
        if (r == 0)      fire = chg;
        else if (r == 1) fire = 3840 + int'($urandom_range(0, 9));
        else             fire = (chg + int'($urandom_range(1, 60))) % 3840;
        mx   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 80));
        r_chg = chg;
        r_fire = fire;
        cfg_write($urandom_range(0, 9) != 0, chg, fire, mx);
    endtask

    function automatic int pick_angle();
        case ($urandom_range(0, 5))
            0:       cur = (r_chg % 3840 + 3838) % 3840;
            1:       cur = int'($urandom_range(0, 3839));
            default: cur = (cur + 1) % 3840;
        endcase
        return cur;
    endfunction

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_coil", longint'(coil), 0);
        chk("reset_fire_pulse", longint'(fire_pulse), 0);
        chk("reset_flags", longint'({dwell_timeout, sync_lost}), 0);
        chk("reset_dwell_last", longint'(dwell_last), 0);

        // Basic charge/fire window
        reconfig(1'b1, 100, 164, 0);
        for (int a = 90; a < 100; a++) begin step(a); idle(1); end
        chk("t1_before_charge", longint'(coil), 0);
        step(100);
        chk("t1_coil_on", longint'(coil), 1);
        idle(1);
        for (int a = 101; a < 164; a++) begin step(a); idle(1); end
        chk("t1_coil_held", longint'(coil), 1);
        step(164);
        chk("t1_fire_pulse", longint'(fire_pulse), 1);
        chk("t1_coil_off", longint'(coil), 0);
        chk("t1_dwell_last", longint'(dwell_last), 128);
        idle(1);
        chk("t1_pulse_one_clk", longint'(fire_pulse), 0);

        // Charge window straddling the revolution wrap
        reconfig(1'b1, 3820, 20, 0);
        for (int a = 3810; a < 3840; a++) begin step(a); idle(1); end
        chk("t2_coil_before_wrap", longint'(coil), 1);
        for (int a = 0; a < 20; a++) begin step(a); idle(1); end
        chk("t2_coil_after_wrap", longint'(coil), 1);
        step(20);
        chk("t2_fire_pulse", longint'(fire_pulse), 1);
        chk("t2_dwell_last", longint'(dwell_last), 80);

        // Dwell limit forces the fire
        reconfig(1'b1, 200, 300, 1000);
        step(200);
        idle(999);
        chk("t3_still_charging", longint'(coil), 1);
        idle(1);
        chk("t3_forced_fire", longint'(fire_pulse), 1);
        chk("t3_timeout_flag", longint'(dwell_timeout), 1);
        chk("t3_dwell_last", longint'(dwell_last), 1000);
        reconfig(1'b1, 100, 164, 0);
        chk("t3_timeout_cleared", longint'(dwell_timeout), 0);

        // Loss of sync while charging
        step(100);
        chk("t4_coil_on", longint'(coil), 1);
        idle(5);
        hwag_start = 1'b0;
        idle(1);
        chk("t4_coil_dropped", longint'(coil), 0);
        chk("t4_no_fire", longint'(fire_pulse), 0);
        chk("t4_sync_lost", longint'(sync_lost), 1);
        hwag_start = 1'b1;
        idle(2);
        step(100);
        chk("t4_rearmed", longint'(coil), 1);

        // Shadow update during charge takes effect only after this fire
        cfg_write(1'b1, 100, 200, 0);
        step(164);
        chk("t5_fire_old_angle", longint'(fire_pulse), 1);
        idle(2);
        step(100);
        idle(1);
        step(164);
        chk("t5_no_fire_at_164", longint'(coil), 1);
        step(200);
        chk("t5_fire_new_angle", longint'(fire_pulse), 1);

        // Equal angles disable the channel
        reconfig(1'b1, 500, 500, 0);
        for (int a = 490; a <= 510; a++) begin
            step(a);
            chk("t6_disabled", longint'(coil), 0);
        end

        // Asynchronous reset during charge
        reconfig(1'b1, 100, 164, 0);
        step(100);
        chk("t6_coil_on", longint'(coil), 1);
        rst = 1'b1;
        #1;
        chk("t6_async_reset", longint'(coil), 0);
        chk("t6_async_no_fire", longint'(fire_pulse), 0);
        #1;
        rst = 1'b0;
        idle(1);

        // Random traffic
        hwag_start = 1'b1;
        rand_cfg();
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)                       hwag_start = 1'b0;
            else if (!hwag_start && r < 20)  hwag_start = 1'b1;
            else if (r < 5)                  rand_cfg();
            else if (r < 75)                 step(pick_angle());
            else                             idle(int'($urandom_range(1, 4)));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
